serial_pattern_ctrl: RTL and testbench

- Sequencer and scanner for the serial 4-bit pattern detector.
- Accepts parallel words over a valid/ready handshake and shifts each word MSB-first through an internal programmable overlapping 4-bit Moore detector.
- Pulses on every match, keeps a saturating match count, and flags end of each word.
- Sits between a word-producing front end and the status/register layer.

---
 rtl/serial_pattern_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_pattern_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_ctrl.sv
// Purpose : accepts parallel words and scans them MSB-first through a programmable overlapping 4-bit Moore detector.
// Latency : word accepted in IDLE, WORD_W SHIFT cycles, one DONE cycle; match pulses one cycle after the completing bit.
// Backpress: in_ready is low outside IDLE and while pat_load is high; an offered word waits until it is taken.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_data/in_valid/in_ready word handshake
//   pattern, pat_load        detect pattern (oldest bit in [3]); loads only in IDLE
//   clear_count              zeroes match_count in any state, wins over an increment
//   busy, match, word_done   status: scanning, hit pulse, end-of-word pulse
//   match_count              saturating hit count
//   last_pos                 (MATCH_POS_EN only) in-word index of the last completing bit, 0 = MSB
//
// Optional feature macro: MATCH_POS_EN adds the last_pos output.
module serial_pattern_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        pattern,
    input  logic              pat_load,
    input  logic              clear_count,
    output logic              busy,
    output logic              match,
    output logic              word_done,
    output logic [CNT_W-1:0]  match_count
`ifdef MATCH_POS_EN
    ,
    output logic [$clog2(WORD_W)-1:0] last_pos
`endif
);

    localparam int POS_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] sreg;
    logic [POS_W-1:0]  bit_idx;
    logic [3:0]        pat_reg;
    logic [3:0]        hist;
    logic [3:0]        hist_nxt;
    logic [2:0]        fill;
    logic [2:0]        fill_nxt;
    logic              hit;
    logic              accept;

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state == IDLE) && !pat_load;
        busy      = (state != IDLE);
        word_done = (state == DONE);
    end

    // Detector view of the bit being shifted this cycle. fill counts valid
    // history bits so a pattern cannot match against the zeroed history
    // left by reset or a pattern load.
    always_comb begin
        hist_nxt = {hist[2:0], sreg[WORD_W-1]};
        fill_nxt = (fill == 3'd4) ? fill : fill + 3'd1;
        hit      = (state == SHIFT) && (hist_nxt == pat_reg) && (fill_nxt == 3'd4);
    end

    // Datapath: shift register, bit counter, pattern and detector history.
    // History is deliberately kept across words so hits can straddle them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_idx <= '0;
            pat_reg <= 4'b1101;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            case (state)
                IDLE: begin
                    if (pat_load) begin
                        pat_reg <= pattern;
                        hist    <= '0;
                        fill    <= '0;
                    end else if (accept) begin
                        sreg    <= in_data;
                        bit_idx <= POS_W'(WORD_W - 1);
                    end
                end
                SHIFT: begin
                    sreg <= {sreg[WORD_W-2:0], 1'b0};
                    hist <= hist_nxt;
                    fill <= fill_nxt;
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating hit counter; clear wins over a simultaneous hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
        end else if (clear_count) begin
            match_count <= '0;
        end else if (hit && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

`ifdef MATCH_POS_EN
    // bit_idx counts down from WORD_W-1, so the in-word position of the
    // completing bit is its complement against WORD_W-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pos <= '0;
        end else if (hit) begin
            last_pos <= POS_W'(WORD_W - 1) - bit_idx;
        end
    end
`endif

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// Purpose : randomized and directed scoreboard bench for serial_pattern_ctrl.
// Latency : expected pulses carry the cycle on which they must appear.
// Backpress: in_ready/busy are checked every driven cycle.
module tb_serial_pattern_ctrl;

    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    pattern = '0;
    logic          pat_load = 1'b0;
    logic          clear_count = 1'b0;
    logic          busy;
    logic          match;
    logic          word_done;
    logic [CW-1:0] match_count;
`ifdef MATCH_POS_EN
    logic [$clog2(W)-1:0] last_pos;
`endif

    serial_pattern_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pattern     (pattern),
        .pat_load    (pat_load),
        .clear_count (clear_count),
        .busy        (busy),
        .match       (match),
        .word_done   (word_done),
        .match_count (match_count)
`ifdef MATCH_POS_EN
        ,
        .last_pos    (last_pos)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int pos;
        int cnt;
        int cyc;
    } exp_t;

    exp_t     sbq[$];
    bit       hq[$];          // most recent bits since reset / pattern load, oldest first
    logic [3:0] pat_m = 4'b1101;
    int       cnt_m = 0;
    int       cyc = 0;
    int       n_cmp = 0;
    int       n_bad = 0;
    int       clr_rate = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit rand_clr();
        return (clr_rate > 0) && ($urandom_range(0, clr_rate - 1) == 0);
    endfunction

    // Reference model for one clock edge.
    task automatic edge_model(input bit shifted, input bit b, input int idx, input bit clr);
        bit hit;
        hit = 1'b0;
        if (shifted) begin
            hq.push_back(b);
            if (hq.size() > 4) void'(hq.pop_front());
            hit = (hq.size() == 4) && ({hq[0], hq[1], hq[2], hq[3]} == pat_m);
        end
        if (clr) cnt_m = 0;
        else if (hit && cnt_m < CMAX) cnt_m++;
        if (hit) sbq.push_back('{1'b0, idx, cnt_m, cyc});
        chk("match_count", int'(match_count), cnt_m);
    endtask

    task automatic step(input string tag, input bit exp_rdy, input bit exp_busy);
        #1;
        chk({tag, "_in_ready"}, int'(in_ready), int'(exp_rdy));
        chk({tag, "_busy"}, int'(busy), int'(exp_busy));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input bit force_clr);
        bit clr;
        clr = force_clr || rand_clr();
        in_valid = 1'b0; pat_load = 1'b0; clear_count = clr;
        step("idle", 1'b1, 1'b0);
        edge_model(1'b0, 1'b0, 0, clr);
        clear_count = 1'b0;
    endtask

    task automatic load_pat(input logic [3:0] p);
        bit clr;
        clr = rand_clr();
        pat_load = 1'b1; pattern = p; in_valid = 1'b1; in_data = W'($urandom); clear_count = clr;
        step("load", 1'b0, 1'b0);
        pat_m = p;
        hq.delete();
        edge_model(1'b0, 1'b0, 0, clr);
        pat_load = 1'b0; in_valid = 1'b0; clear_count = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int clr_at, input bit noise, input int rst_at);
        bit clr;
        clr = rand_clr();
        pat_load = 1'b0; in_valid = 1'b1; in_data = w; clear_count = clr;
        step("accept", 1'b1, 1'b0);
        edge_model(1'b0, 1'b0, 0, clr);
        for (int i = 0; i < W; i++) begin
            clr = (i == clr_at) || rand_clr();
            clear_count = clr;
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = W'($urandom);
            pat_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            pattern  = 4'($urandom);
            if (i == rst_at) rst = 1'b1;
            step("shift", 1'b0, 1'b1);
            if (i == rst_at) begin
                rst = 1'b0; clear_count = 1'b0; pat_load = 1'b0; in_valid = 1'b0;
                pat_m = 4'b1101; hq.delete(); cnt_m = 0;
                chk("rst_match", int'(match), 0);
                chk("rst_word_done", int'(word_done), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_count", int'(match_count), 0);
                return;
            end
            edge_model(1'b1, w[W-1-i], i, clr);
        end
        sbq.push_back('{1'b1, 0, 0, cyc});
        clr = rand_clr();
        clear_count = clr;
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        pat_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        pattern  = 4'($urandom);
        step("done", 1'b0, 1'b1);
        edge_model(1'b0, 1'b0, 0, clr);
        clear_count = 1'b0; pat_load = 1'b0; in_valid = 1'b0;
    endtask

    // Monitor: every pulse the DUT presents must match the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (match === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_match", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("match_kind", 0, int'(e.is_done));
                chk("match_cycle", cyc, e.cyc);
                chk("match_cnt_at_pulse", int'(match_count), e.cnt);
`ifdef MATCH_POS_EN
                chk("last_pos", int'(last_pos), e.pos);
`endif
            end
        end
        if (word_done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_word_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("done_kind", 1, int'(e.is_done));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_count", int'(match_count), 0);
        chk("reset_match", int'(match), 0);
        chk("reset_word_done", int'(word_done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 1);

        // Default pattern, overlapping hits at bits 3 and 6
        send_word(8'hDA, -1, 1'b0, -1);
        chk("da_count", int'(match_count), 2);

        // Cross-word hit
        idle_cycle(1'b1);
        load_pat(4'b1101);
        send_word(8'h06, -1, 1'b0, -1);
        send_word(8'h80, -1, 1'b0, -1);
        chk("cross_count", int'(match_count), 1);

        // New pattern; pat_load noise while busy must be ignored
        idle_cycle(1'b1);
        load_pat(4'b0011);
        send_word(8'h33, -1, 1'b1, -1);
        chk("p0011_count", int'(match_count), 2);
        send_word(8'h33, -1, 1'b0, -1);

        // Saturation, then clear coincident with a hit
        load_pat(4'b0000);
        send_word(8'h00, -1, 1'b0, -1);
        chk("sat_count", int'(match_count), CMAX);
        send_word(8'h00, 5, 1'b0, -1);
        chk("clr_hit_count", int'(match_count), 2);

        // Reset mid-word restores the default pattern
        load_pat(4'b0110);
        send_word(8'hDA, -1, 1'b0, 2);
        send_word(8'hDA, -1, 1'b0, -1);
        chk("post_rst_count", int'(match_count), 2);

        // Randomized traffic
        clr_rate = 6;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: load_pat(4'($urandom));
                1: repeat ($urandom_range(1, 3)) idle_cycle(1'b0);
                default: ;
            endcase
            send_word(W'($urandom), -1, 1'b1, -1);
        end
        clr_rate = 0;
        repeat (3) idle_cycle(1'b0);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
